rr_arbiter8: RTL and testbench

- Eight-requester round-robin arbiter with a hold quantum. It shares one downstream resource, such as a display or LED channel driven from the NVBoard inputs, between eight request lines.
- It produces a registered one-hot grant, a 3-bit binary grant index and a valid flag. These have the same id/flag semantics as the team's 8-to-3 priority encoder, but fairness comes from a rotating pointer instead of fixed priority.
- A per-grant hold counter forces rotation when other requesters are waiting.

---
 rtl/rr_arbiter8.sv | 166 ++++++++++++++++
 tb/tb_rr_arbiter8.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8
//  Description : Eight-requester round-robin arbiter with a hold quantum.
//                A rotating search origin (last owner + 1) gives fairness.
//                A per-grant hold counter forces the grant away from an owner
//                that has held it for MAX_HOLD cycles while others wait.
//  Ports       : clk        - system clock, rising edge
//                rst_n      - synchronous active-low reset
//                ena        - arbiter enable; low drops any grant
//                req[7:0]   - request lines, level sensitive
//                gnt[7:0]   - registered one-hot grant, zero when idle
//                gnt_id[2:0]- binary index of the granted requester
//                gnt_valid  - high exactly when gnt is non-zero
//                rot        - one-cycle pulse after a forced rotation
//  Parameters  : MAX_HOLD   - hold quantum in cycles (0 = unlimited), 0..255
//                CNT_W      - hold counter width, 2**CNT_W > MAX_HOLD
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       rot
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       last_owner, owner_nxt;
    logic [CNT_W-1:0] hold_cnt, cnt_nxt, cnt_inc;
    logic [7:0]       gnt_nxt;
    logic [2:0]       id_nxt;
    logic             valid_nxt;
    logic             rot_nxt;

    logic [7:0]       scan_req;
    logic [2:0]       winner;
    logic             found;
    logic             quantum_hit;

    // Masking with the current grant keeps the owner out of the scan, so a
    // forced rotation can never hand the grant straight back to it. In IDLE
    // gnt is zero and nothing is masked.
    assign scan_req = req & ~gnt;

    // Circular scan starting one past the last owner; first set bit wins.
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = last_owner + 3'(i + 1);
            if (!found && scan_req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign quantum_hit = (MAX_HOLD != 0) && (hold_cnt == MAX_CNT);

    // Saturating increment: at MAX_HOLD normally, at all-ones when unlimited.
    always_comb begin
        cnt_inc = hold_cnt + ONE_CNT;
        if (MAX_HOLD == 0) begin
            if (&hold_cnt) begin
                cnt_inc = hold_cnt;
            end
        end else if (hold_cnt >= MAX_CNT) begin
            cnt_inc = MAX_CNT;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        owner_nxt = last_owner;
        cnt_nxt   = hold_cnt;
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        valid_nxt = gnt_valid;
        rot_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (ena && found) begin
                    state_nxt = GRANT;
                    owner_nxt = winner;
                    cnt_nxt   = ONE_CNT;
                    gnt_nxt   = 8'b1 << winner;
                    id_nxt    = winner;
                    valid_nxt = 1'b1;
                end else begin
                    gnt_nxt   = 8'd0;
                    id_nxt    = 3'd0;
                    valid_nxt = 1'b0;
                end
            end

            GRANT: begin
                if (!ena || (!req[last_owner] && !found)) begin
                    // Disabled, or owner released with nobody waiting.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    gnt_nxt   = 8'd0;
                    id_nxt    = 3'd0;
                    valid_nxt = 1'b0;
                end else if (!req[last_owner] || (quantum_hit && found)) begin
                    // Hand-over without an idle gap; only the quantum case
                    // (owner still requesting) raises rot.
                    owner_nxt = winner;
                    cnt_nxt   = ONE_CNT;
                    gnt_nxt   = 8'b1 << winner;
                    id_nxt    = winner;
                    valid_nxt = 1'b1;
                    rot_nxt   = req[last_owner];
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end

            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 8'd0;
                id_nxt    = 3'd0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= 3'd7;
            hold_cnt   <= '0;
            gnt        <= 8'd0;
            gnt_id     <= 3'd0;
            gnt_valid  <= 1'b0;
            rot        <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_owner <= owner_nxt;
            hold_cnt   <= cnt_nxt;
            gnt        <= gnt_nxt;
            gnt_id     <= id_nxt;
            gnt_valid  <= valid_nxt;
            rot        <= rot_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter8
//  Description : Self-checking bench for rr_arbiter8 (MAX_HOLD = 4). A
//                behavioural reference model pushes expected outputs into a
//                queue at every rising edge; they are popped and compared on
//                the falling edge. Directed checks cover the scenario list.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

    localparam int MAXH = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       rot;

    rr_arbiter8 #(
        .MAX_HOLD (MAXH),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .rot       (rot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       r;
    } exp_t;

    exp_t exp_q[$];

    bit         m_grant;
    int         m_owner;
    int         m_cnt;
    logic [7:0] m_gnt;
    bit         m_rot;

    function automatic int pick(input logic [7:0] r, input int owner);
        for (int k = 1; k <= 8; k++) begin
            if (r[(owner + k) % 8]) return (owner + k) % 8;
        end
        return -1;
    endfunction

    task automatic m_take(input int w);
        m_grant = 1'b1;
        m_owner = w;
        m_cnt   = 1;
        m_gnt   = 8'h01 << w;
    endtask

    task automatic m_idle();
        m_grant = 1'b0;
        m_gnt   = 8'h00;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        logic [7:0] others;
        exp_t e;
        if (!rst_n) begin
            m_idle();
            m_owner = 7;
            m_rot   = 1'b0;
        end else begin
            m_rot = 1'b0;
            if (!m_grant) begin
                if (ena && req != 8'h00) m_take(pick(req, m_owner));
                else                     m_idle();
            end else begin
                others = req & ~(8'h01 << m_owner);
                if (!ena) begin
                    m_idle();
                end else if (!req[m_owner]) begin
                    if (others != 8'h00) m_take(pick(others, m_owner));
                    else                 m_idle();
                end else if (MAXH != 0 && m_cnt == MAXH && others != 8'h00) begin
                    m_take(pick(others, m_owner));
                    m_rot = 1'b1;
                end else if (MAXH == 0) begin
                    m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
                end else begin
                    m_cnt = (m_cnt < MAXH) ? m_cnt + 1 : MAXH;
                end
            end
        end
        e.g  = m_gnt;
        e.id = m_grant ? 3'(m_owner) : 3'd0;
        e.v  = m_grant;
        e.r  = m_rot;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) model_step();

    function automatic logic [2:0] onehot_idx(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
        return r;
    endfunction

    task automatic score();
        exp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("sb_gnt",       32'(gnt),       32'(e.g));
        check("sb_gnt_id",    32'(gnt_id),    32'(e.id));
        check("sb_gnt_valid", 32'(gnt_valid), 32'(e.v));
        check("sb_rot",       32'(rot),       32'(e.r));
        // Structural consistency of the outputs in every cycle.
        check("onehot", 32'($countones(gnt) <= 1), 32'(1));
        check("valid_eq_or", 32'(gnt_valid), 32'(|gnt));
        check("id_matches_gnt", 32'(gnt_id), 32'(onehot_idx(gnt)));
    endtask

    always @(negedge clk) score();

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int         cur;
        logic [7:0] cur_g;
        int         rr_exp[3];

        rr_exp[0] = 4;
        rr_exp[1] = 7;
        rr_exp[2] = 1;

        rst_n = 1'b0;
        ena   = 1'b1;
        req   = 8'hFF;

        // Reset held for two edges with everyone requesting.
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt",   32'(gnt),       32'h00);
        check("rst_id",    32'(gnt_id),    32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_rst_gnt", 32'(gnt),    32'h01);
        check("post_rst_id",  32'(gnt_id), 32'h0);

        // Round robin with owner release, wrap 7 -> 1.
        req = 8'h00;
        tick();
        req = 8'b1001_0010;
        tick();
        check("rr_first", 32'(gnt_id), 32'd1);
        cur = 1;
        for (int i = 0; i < 3; i++) begin
            req = 8'b1001_0010 & ~(8'h01 << cur);
            tick();
            check("rr_order", 32'(gnt_id),    32'(rr_exp[i]));
            check("rr_nogap", 32'(gnt_valid), 32'd1);
            cur = rr_exp[i];
        end

        // Quantum expiry alternation between 0 and 1.
        req = 8'h00;
        tick();
        req = 8'h03;
        tick();
        cur_g = 8'h01;
        check("q_first", 32'(gnt), 32'(cur_g));
        for (int r = 0; r < 3; r++) begin
            repeat (3) begin
                tick();
                check("q_hold", 32'(gnt), 32'(cur_g));
                check("q_norot", 32'(rot), 32'd0);
            end
            tick();
            cur_g = (cur_g == 8'h01) ? 8'h02 : 8'h01;
            check("q_rotate", 32'(gnt), 32'(cur_g));
            check("q_rot", 32'(rot), 32'd1);
        end

        // Lone requester never rotates.
        req = 8'h20;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("lone_gnt", 32'(gnt),    32'h20);
            check("lone_id",  32'(gnt_id), 32'd5);
            check("lone_rot", 32'(rot),    32'd0);
        end

        // Enable drop while 3 is granted; origin then moves to 4.
        req = 8'h08;
        tick();
        check("en_owner3", 32'(gnt_id), 32'd3);
        ena = 1'b0;
        req = 8'h18;
        tick();
        check("en_drop", 32'(gnt), 32'h00);
        ena = 1'b1;
        tick();
        check("en_origin4", 32'(gnt_id), 32'd4);

        // Mid-grant reset returns the origin to 0 (7 would win otherwise).
        rst_n = 1'b0;
        req   = 8'h81;
        tick();
        check("mrst_gnt", 32'(gnt), 32'h00);
        rst_n = 1'b1;
        tick();
        check("mrst_origin0", 32'(gnt), 32'h01);

        // Release coincident with quantum expiry: no rot.
        req = 8'h00;
        tick();
        req = 8'h03;
        tick();
        check("co_owner1", 32'(gnt), 32'h02);
        repeat (3) begin
            tick();
            check("co_hold", 32'(gnt), 32'h02);
        end
        req = 8'h01;
        tick();
        check("co_move", 32'(gnt), 32'h01);
        check("co_norot", 32'(rot), 32'd0);

        req = 8'h00;
        repeat (3) tick();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
